// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and frame constants for the SPI responder
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 8;
    localparam int RD_BIT     = 15;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchronizer plus history flop with edge detect
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    // sh[0], sh[1] form the synchronizer; sh[2] remembers the previous synced value.
    // Resetting to 0 means a select line held low across reset never looks like a fall.
    logic [2:0] sh;

    // shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= 3'b000;
        end else begin
            sh <= {sh[1:0], din};
        end
    end

    assign sync = sh[1];
    assign rise = sh[1] & ~sh[2];
    assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/spi_resp.sv
// rtl/spi_resp.sv - SPI mode-0 responder with byte register file and data-ready INT
module spi_resp
    import spi_pkg::*;
#(
    parameter int         NUM_REGS      = 64,
    parameter logic [6:0] WHO_AM_I_ADDR = 7'h0F,
    parameter logic [7:0] WHO_AM_I_VAL  = 8'h6A,
    parameter logic [6:0] INT_CLR_ADDR  = 7'h27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic       loc_wr,
    input  logic [6:0] loc_addr,
    input  logic [7:0] loc_data,
    input  logic       set_int,
    output logic       INT,
    output logic       wrt_vld,
    output logic [6:0] wrt_addr,
    output logic [7:0] wrt_data,
    output logic       frm_err
);

    logic ss_sync, ss_rise, ss_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge u_ss_sync (
        .clk(clk), .rst_n(rst_n), .din(SS_n),
        .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(SCLK),
        .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge u_mosi_sync (
        .clk(clk), .rst_n(rst_n), .din(MOSI),
        .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sclk_sync, mosi_rise, mosi_fall};

    state_t                  state, state_nxt;
    logic                    start, finish;
    logic [4:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   rx, tx, rx_nxt;
    logic [7:0]              regs [NUM_REGS];
    logic [7:0]              rd_data;
    logic [6:0]              rd_addr;
    logic                    int_q;

    logic       commit, frame_bad;
    logic       cmd_rd;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       spi_wr, spi_int_clr;

    // frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // frame start/end decode from synced slave-select edges
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt = SHIFT;
                    start     = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_nxt  = {rx[FRAME_BITS-2:0], mosi_sync};
    assign rd_addr = rx_nxt[6:0];

    // read mux for the address just completed by the 8th SCLK rise
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 7'(i)) begin
                rd_data = regs[i];
            end
        end
        if (rd_addr == WHO_AM_I_ADDR) begin
            rd_data = WHO_AM_I_VAL;
        end
    end

    // shift registers and bit counter; read data is loaded one bit below MSB so
    // the 8th fall presents bit7 ahead of the master's 9th rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 5'd0;
            rx      <= '0;
            tx      <= '0;
        end else if (start) begin
            bit_cnt <= 5'd0;
            rx      <= '0;
            tx      <= '0;
        end else if (state == SHIFT && !ss_sync) begin
            if (sclk_rise) begin
                rx <= rx_nxt;
                if (bit_cnt != 5'd31) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
                if (bit_cnt == 5'(CMD_BITS - 1) && rx_nxt[CMD_BITS-1]) begin
                    tx[14:7] <= rd_data;
                end
            end else if (sclk_fall) begin
                tx <= {tx[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    assign MISO = (state == SHIFT) && !ss_sync && tx[FRAME_BITS-1];

    assign cmd_rd      = rx[RD_BIT];
    assign cmd_addr    = rx[14:8];
    assign cmd_data    = rx[7:0];
    assign commit      = finish && (bit_cnt == 5'(FRAME_BITS));
    assign frame_bad   = finish && (bit_cnt != 5'(FRAME_BITS));
    assign spi_wr      = commit && !cmd_rd;
    assign spi_int_clr = commit && cmd_rd && (cmd_addr == INT_CLR_ADDR);

    // register file: SPI commit has priority over a local write to the same byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (7'(i) != WHO_AM_I_ADDR) begin
                    if (spi_wr && cmd_addr == 7'(i)) begin
                        regs[i] <= cmd_data;
                    end else if (loc_wr && loc_addr == 7'(i)) begin
                        regs[i] <= loc_data;
                    end
                end
            end
        end
    end

    // write notification, framing error pulse and data-ready interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt_vld  <= 1'b0;
            wrt_addr <= 7'd0;
            wrt_data <= 8'd0;
            frm_err  <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            wrt_vld <= spi_wr;
            frm_err <= frame_bad;
            if (spi_wr) begin
                wrt_addr <= cmd_addr;
                wrt_data <= cmd_data;
            end
            if (set_int) begin
                int_q <= 1'b1;
            end else if (spi_int_clr) begin
                int_q <= 1'b0;
            end
        end
    end

    assign INT = int_q;

endmodule

// File: tb/tb_spi_resp.sv
// tb/tb_spi_resp.sv - self-checking bench for spi_resp with a register-file reference model
module tb_spi_resp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic       loc_wr = 1'b0;
    logic [6:0] loc_addr = 7'd0;
    logic [7:0] loc_data = 8'd0;
    logic       set_int = 1'b0;
    logic       INT;
    logic       wrt_vld;
    logic [6:0] wrt_addr;
    logic [7:0] wrt_data;
    logic       frm_err;

    spi_resp dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .loc_wr(loc_wr), .loc_addr(loc_addr), .loc_data(loc_data), .set_int(set_int),
        .INT(INT), .wrt_vld(wrt_vld), .wrt_addr(wrt_addr), .wrt_data(wrt_data),
        .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: 64 bytes, fixed ID at 0x0F, INT flag
    logic [7:0] m_regs [128];
    logic       m_int;

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        if (a == 7'h0F) return 8'h6A;
        if (a < 7'd64) return m_regs[a];
        return 8'h00;
    endfunction

    function automatic void model_wr(input logic [6:0] a, input logic [7:0] d);
        if (a < 7'd64 && a != 7'h0F) m_regs[a] = d;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
        m_int = 1'b0;
    endfunction

    // pulse monitor
    int         wrt_cnt = 0;
    int         frm_cnt = 0;
    logic [6:0] last_wa = 7'd0;
    logic [7:0] last_wd = 8'd0;

    always @(negedge clk) begin
        if (wrt_vld) begin
            wrt_cnt++;
            last_wa = wrt_addr;
            last_wd = wrt_data;
        end
        if (frm_err) frm_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ss_low();
        SS_n = 1'b0;
        tick(8);
    endtask

    task automatic ss_high();
        tick(4);
        SS_n = 1'b1;
    endtask

    task automatic spi_bit(input logic b, output logic m);
        MOSI = b;
        tick(8);
        SCLK = 1'b1;
        m = MISO;
        tick(8);
        SCLK = 1'b0;
    endtask

    task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [15:0] r);
        logic m;
        r = 16'h0000;
        ss_low();
        for (int i = 0; i < nbits; i++) begin
            spi_bit(w[15-i], m);
            r[15-i] = m;
        end
        ss_high();
    endtask

    task automatic spi_read(input logic [6:0] a, output logic [7:0] d);
        logic [15:0] r;
        spi_frame({1'b1, a, 8'h00}, 16, r);
        tick(8);
        d = r[7:0];
        n_vec++;
        if (r[15:8] !== 8'h00) begin
            n_err++;
            $display("FAIL cmd_miso_zero addr=%h: got %h expected 00", a, r[15:8]);
        end
        if (a == 7'h27) m_int = 1'b0;
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        logic [15:0] r;
        int w0;
        w0 = wrt_cnt;
        spi_frame({1'b0, a, d}, 16, r);
        tick(8);
        model_wr(a, d);
        n_vec++;
        if (wrt_cnt !== w0 + 1 || last_wa !== a || last_wd !== d) begin
            n_err++;
            $display("FAIL wrt_pulse: got cnt+%0d addr=%h data=%h expected cnt+1 addr=%h data=%h",
                     wrt_cnt - w0, last_wa, last_wd, a, d);
        end
    endtask

    task automatic local_write(input logic [6:0] a, input logic [7:0] d);
        loc_wr = 1'b1; loc_addr = a; loc_data = d;
        tick(1);
        loc_wr = 1'b0;
        model_wr(a, d);
    endtask

    task automatic pulse_int();
        set_int = 1'b1;
        tick(1);
        set_int = 1'b0;
        m_int = 1'b1;
    endtask

    task automatic check_read(input string nm, input logic [6:0] a);
        logic [7:0] d, exp;
        exp = model_rd(a);
        spi_read(a, d);
        n_vec++;
        if (d !== exp) begin
            n_err++;
            $display("FAIL %s addr=%h: got %h expected %h", nm, a, d, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        model_reset();
        n_vec++;
        if ({MISO, INT, wrt_vld, wrt_addr, wrt_data, frm_err} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got MISO=%b INT=%b vld=%b addr=%h data=%h ferr=%b expected all zero",
                     MISO, INT, wrt_vld, wrt_addr, wrt_data, frm_err);
        end
    endtask

    task automatic test_who_am_i();
        int w0, f0;
        w0 = wrt_cnt; f0 = frm_cnt;
        check_read("who_am_i", 7'h0F);
        n_vec++;
        if (wrt_cnt !== w0 || frm_cnt !== f0) begin
            n_err++;
            $display("FAIL who_am_i_pulses: got wrt=%0d ferr=%0d expected 0 0", wrt_cnt - w0, frm_cnt - f0);
        end
    endtask

    task automatic test_write_read();
        spi_write(7'h10, 8'h55);
        check_read("write_readback", 7'h10);
    endtask

    task automatic test_int();
        logic [15:0] r;
        local_write(7'h27, 8'hCD);
        pulse_int();
        n_vec++;
        if (INT !== 1'b1) begin
            n_err++;
            $display("FAIL int_set: got %b expected 1", INT);
        end
        spi_frame(16'hA700, 16, r);
        n_vec++;
        if (r[7:0] !== model_rd(7'h27)) begin
            n_err++;
            $display("FAIL int_reg_read: got %h expected %h", r[7:0], model_rd(7'h27));
        end
        tick(2);
        n_vec++;
        if (INT !== 1'b1) begin
            n_err++;
            $display("FAIL int_hold_2clk: got %b expected 1", INT);
        end
        tick(1);
        m_int = 1'b0;
        n_vec++;
        if (INT !== 1'b0) begin
            n_err++;
            $display("FAIL int_clear_3clk: got %b expected 0", INT);
        end
        tick(6);
    endtask

    task automatic test_protected();
        spi_write(7'h0F, 8'h12);
        check_read("who_am_i_after_wr", 7'h0F);
        check_read("out_of_range", 7'h50);
    endtask

    task automatic test_frame_err();
        logic [15:0] r;
        int w0, f0;
        pulse_int();
        w0 = wrt_cnt; f0 = frm_cnt;
        spi_frame(16'h2077, 10, r);
        tick(8);
        n_vec++;
        if (frm_cnt !== f0 + 1 || wrt_cnt !== w0 || INT !== 1'b1) begin
            n_err++;
            $display("FAIL frame_err: got ferr+%0d wrt+%0d INT=%b expected 1 0 1",
                     frm_cnt - f0, wrt_cnt - w0, INT);
        end
        check_read("short_frame_no_write", 7'h20);
    endtask

    task automatic test_collision();
        logic m;
        ss_low();
        for (int i = 0; i < 16; i++) spi_bit(1'b0 ? 1'b0 : (16'h30AA >> (15 - i)) & 1'b1, m);
        tick(4);
        SS_n = 1'b1;
        tick(2);
        loc_wr = 1'b1; loc_addr = 7'h30; loc_data = 8'h11;
        tick(1);
        loc_wr = 1'b0;
        m_regs[7'h30] = 8'hAA;
        tick(8);
        check_read("collision_spi_wins", 7'h30);
    endtask

    task automatic test_random();
        int op;
        logic [6:0] a;
        logic [7:0] d;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(64, 127)) : 7'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = 7'h27;
            d = 8'($urandom);
            case (op)
                0: local_write(a, d);
                1: spi_write(a, d);
                2: check_read("random_read", a);
                default: pulse_int();
            endcase
            tick(2);
            n_vec++;
            if (INT !== m_int) begin
                n_err++;
                $display("FAIL random_int it=%0d op=%0d: got %b expected %b", it, op, INT, m_int);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic m;
        logic [15:0] w;
        int w0, f0;
        local_write(7'h05, 8'h3C);
        spi_write(7'h06, 8'h99);
        w = 16'h8F00;
        ss_low();
        for (int i = 0; i < 12; i++) spi_bit(w[15-i], m);
        tick(4);
        n_vec++;
        if (MISO !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_bit3: got %b expected 1", MISO);
        end
        w0 = wrt_cnt; f0 = frm_cnt;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (MISO !== 1'b0) begin
            n_err++;
            $display("FAIL reset_miso: got %b expected 0", MISO);
        end
        tick(2);
        rst_n = 1'b1;
        model_reset();
        n_vec++;
        if ({INT, wrt_addr, wrt_data} !== 16'd0) begin
            n_err++;
            $display("FAIL reset_midframe_outs: got INT=%b addr=%h data=%h expected 0", INT, wrt_addr, wrt_data);
        end
        for (int i = 12; i < 16; i++) begin
            spi_bit(w[15-i], m);
            n_vec++;
            if (m !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_miso bit=%0d: got %b expected 0", i, m);
            end
        end
        ss_high();
        tick(8);
        n_vec++;
        if (wrt_cnt !== w0 || frm_cnt !== f0) begin
            n_err++;
            $display("FAIL post_reset_ignored: got wrt+%0d ferr+%0d expected 0 0", wrt_cnt - w0, frm_cnt - f0);
        end
        check_read("reset_clears_05", 7'h05);
        check_read("reset_clears_06", 7'h06);
        check_read("restart_who_am_i", 7'h0F);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_who_am_i();
        test_write_read();
        test_int();
        test_protected();
        test_frame_err();
        test_collision();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
